ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning bit width of one stage's control word.
REQ-002 SHALL have parameter DEPTH, default 3, meaning number of cascaded stages (range 1..8).
REQ-003 SHALL have parameter NOP_VALUE, default all-zero WIDTH bits, meaning the word loaded on flush, bubble or reset.
REQ-004 SHALL have parameter CNT_W, default 16, meaning width of each event counter.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port ctrl_in  input  WIDTH  control word entering stage 0.
REQ-008 SHALL have port valid_in  input  1  ctrl_in carries a real instruction.
REQ-009 SHALL have port ready_in  output  1  stage 0 accepts ctrl_in this cycle.
REQ-010 SHALL have port bubble_vec  input  DEPTH  bit i requests that stage i hold its contents.
REQ-011 SHALL have port flush_vec  input  DEPTH  bit i requests that stage i load NOP_VALUE.
REQ-012 SHALL have port cnt_clear  input  1  synchronous clear of both counters.
REQ-013 SHALL have port ctrl_out  output  DEPTH*WIDTH  stage i word at bits [i*WIDTH +: WIDTH].
REQ-014 SHALL have port valid_out  output  DEPTH  valid bit of each stage.
REQ-015 SHALL have port bubble_cnt  output  CNT_W  count of cycles in which any auto-bubble was inserted.
REQ-016 SHALL have port flush_cnt  output  CNT_W  count of cycles in which any flush took effect.

Function
REQ-017 SHALL compute hold[DEPTH-1] = bubble_vec[DEPTH-1] and hold[i] = bubble_vec[i] | hold[i+1]: a stall propagates to all upstream stages in the same cycle.
REQ-018 SHALL drive ready_in = ~hold[0], combinationally.
REQ-019 SHALL, per stage per cycle, apply this priority: hold[i] -> keep word and valid; else flush_vec[i] -> NOP_VALUE, valid 0; else upstream held (hold[i-1], i>0) -> NOP_VALUE, valid 0 (auto-bubble); else load upstream word and valid.
REQ-020 SHALL take stage 0's upstream as ctrl_in/valid_in; stage 0 never auto-bubbles.
REQ-021 SHALL ignore flush_vec[i] while hold[i] is 1 (hold wins, no pending flush retained).
REQ-022 SHALL give a latency of exactly i+1 cycles from ctrl_in accepted to appearance at stage i, absent holds.
REQ-023 SHALL increment bubble_cnt by 1 in any cycle where at least one stage auto-bubbles, saturating at 2^CNT_W-1.
REQ-024 SHALL increment flush_cnt by 1 in any cycle where at least one stage loads NOP via flush (REQ-019 branch 2), saturating at 2^CNT_W-1.
REQ-025 SHALL, when cnt_clear=1, load both counters with 0 that cycle, overriding increments.
REQ-026 SHALL make ctrl_out and valid_out register outputs with no combinational path from inputs.

Reset
REQ-027 SHALL, while rst=1, asynchronously force every stage word to NOP_VALUE, every valid bit to 0, both counters to 0.
REQ-028 SHALL abandon any in-flight stall or flush on rst; first edge after rst deasserts follows REQ-019 from the reset state.

Structure
REQ-029 SHALL place NOP_VALUE default and the stage-control field offsets (wb_select, load_type, reg_write_en, cache_write_en, cache_read_en) in shared package ctrl_pipe_pkg.
REQ-030 SHALL build each stage as instance of sub-module ctrl_pipe_stage (one word+valid register with hold/flush/bubble/load select), generated DEPTH times.

Verification
REQ-031 SHALL cover streaming: DEPTH=3, words 0x001,0x002,0x003 valid on consecutive cycles, no holds -> 0x001 at stage 2 on cycle 3, valid_out=3'b111 on cycle 3.
REQ-032 SHALL cover mid-pipe stall: bubble_vec=3'b010 for one cycle with 0x0A5 in stage 1 -> stages 0,1 hold, ready_in=0, stage 2 gets NOP valid 0, bubble_cnt=1.
REQ-033 SHALL cover hold-over-flush: bubble_vec=3'b001 and flush_vec=3'b001 together -> stage 0 retains word, flush_cnt unchanged.
REQ-034 SHALL cover flush: flush_vec=3'b011 with valid data in all stages -> stages 0,1 NOP valid 0, stage 2 receives old stage-1 word, flush_cnt=1.
REQ-035 SHALL cover saturation/clear: CNT_W=2, four bubble cycles -> bubble_cnt stays 3; cnt_clear=1 with bubble -> 0.
REQ-036 SHALL cover async reset mid-stall: rst pulse between clock edges while bubble_vec=3'b100 -> outputs NOP, valid 0, counters 0 immediately, before next edge.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control-word pipeline: field layout, NOP word and
// the per-stage next-state selector.
package ctrl_pipe_pkg;

  localparam int unsigned CTRL_W = 10;

  // Field offsets inside one stage control word
  localparam int unsigned WB_SELECT_LSB      = 0;
  localparam int unsigned WB_SELECT_W        = 2;
  localparam int unsigned LOAD_TYPE_LSB      = 2;
  localparam int unsigned LOAD_TYPE_W        = 3;
  localparam int unsigned REG_WRITE_EN_BIT   = 5;
  localparam int unsigned CACHE_WRITE_EN_BIT = 6;
  localparam int unsigned CACHE_READ_EN_BIT  = 7;
  localparam int unsigned SPARE_LSB          = 8;
  localparam int unsigned SPARE_W            = 2;

  typedef struct packed {
    logic [SPARE_W-1:0]     spare;
    logic                   cache_read_en;
    logic                   cache_write_en;
    logic                   reg_write_en;
    logic [LOAD_TYPE_W-1:0] load_type;
    logic [WB_SELECT_W-1:0] wb_select;
  } ctrl_word_t;

  // NOP leaves every enable low and selects nothing
  localparam ctrl_word_t            CTRL_NOP = '0;
  localparam logic [CTRL_W-1:0]     NOP_WORD = CTRL_NOP;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_FLUSH  = 2'd1,
    SEL_BUBBLE = 2'd2,
    SEL_LOAD   = 2'd3
  } stage_sel_e;

  // Priority: own hold, then flush, then upstream hold (bubble), then load
  function automatic stage_sel_e stage_sel(input logic hold,
                                           input logic flush,
                                           input logic up_hold);
    stage_sel_e sel;
    if (hold)         sel = SEL_HOLD;
    else if (flush)   sel = SEL_FLUSH;
    else if (up_hold) sel = SEL_BUBBLE;
    else              sel = SEL_LOAD;
    return sel;
  endfunction

endpackage : ctrl_pipe_pkg

// File: rtl/ctrl_pipe_stage.sv
// One pipeline stage: word + valid register with hold/flush/bubble/load select.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = CTRL_W,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_WORD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             up_hold,
  input  logic [WIDTH-1:0] up_word,
  input  logic             up_valid,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic             flush_hit_c,
  output logic             bubble_hit_c
);

  stage_sel_e       sel;
  logic [WIDTH-1:0] word_d;
  logic             valid_d;

  always_comb begin
    sel          = stage_sel(hold, flush, up_hold);
    word_d       = word;
    valid_d      = valid;
    flush_hit_c  = 1'b0;
    bubble_hit_c = 1'b0;
    unique case (sel)
      SEL_HOLD: begin
        word_d  = word;
        valid_d = valid;
      end
      SEL_FLUSH: begin
        word_d      = NOP_VALUE;
        valid_d     = 1'b0;
        flush_hit_c = 1'b1;
      end
      SEL_BUBBLE: begin
        word_d       = NOP_VALUE;
        valid_d      = 1'b0;
        bubble_hit_c = 1'b1;
      end
      SEL_LOAD: begin
        word_d  = up_word;
        valid_d = up_valid;
      end
      default: begin
        word_d  = word;
        valid_d = valid;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= NOP_VALUE;
      valid <= 1'b0;
    end else begin
      word  <= word_d;
      valid <= valid_d;
    end
  end

endmodule : ctrl_pipe_stage

// File: rtl/ctrl_pipe.sv
// Cascaded control-word pipeline with backward stall propagation, per-stage
// flush and saturating bubble/flush event counters.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = CTRL_W,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_WORD),
  parameter int unsigned      CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       ctrl_in,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [DEPTH-1:0]       bubble_vec,
  input  logic [DEPTH-1:0]       flush_vec,
  input  logic                   cnt_clear,
  output logic [DEPTH*WIDTH-1:0] ctrl_out,
  output logic [DEPTH-1:0]       valid_out,
  output logic [CNT_W-1:0]       bubble_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] flush_hit;
  logic [DEPTH-1:0] bubble_hit;
  logic [WIDTH-1:0] stage_word [DEPTH];

  // A stall at stage i freezes every stage upstream of it in the same cycle
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      acc     = acc | bubble_vec[i];
      hold[i] = acc;
    end
  end

  assign ready_in = ~hold[0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_hold;
    logic             up_valid;
    logic [WIDTH-1:0] up_word;

    if (i == 0) begin : g_head
      assign up_hold  = 1'b0;
      assign up_word  = ctrl_in;
      assign up_valid = valid_in;
    end else begin : g_body
      assign up_hold  = hold[i-1];
      assign up_word  = stage_word[i-1];
      assign up_valid = valid_out[i-1];
    end

    ctrl_pipe_stage #(
      .WIDTH     (WIDTH),
      .NOP_VALUE (NOP_VALUE)
    ) u_stage (
      .clk          (clk),
      .rst          (rst),
      .hold         (hold[i]),
      .flush        (flush_vec[i]),
      .up_hold      (up_hold),
      .up_word      (up_word),
      .up_valid     (up_valid),
      .word         (stage_word[i]),
      .valid        (valid_out[i]),
      .flush_hit_c  (flush_hit[i]),
      .bubble_hit_c (bubble_hit[i])
    );
  end

  always_comb begin
    ctrl_out = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ctrl_out[i*WIDTH +: WIDTH] = stage_word[i];
    end
  end

  // Event counters count cycles, not stages; clear beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (cnt_clear) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if ((|bubble_hit) && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
      if ((|flush_hit) && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule : ctrl_pipe

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a DEPTH=3 instance plus a CNT_W=2 twin for
// counter saturation, both driven from the same stimulus.
module tb_ctrl_pipe;

  localparam int unsigned W = 10;
  localparam int unsigned D = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   ctrl_in;
  logic           valid_in;
  logic [D-1:0]   bubble_vec;
  logic [D-1:0]   flush_vec;
  logic           cnt_clear;

  logic           ready_in;
  logic [D*W-1:0] ctrl_out;
  logic [D-1:0]   valid_out;
  logic [15:0]    bubble_cnt;
  logic [15:0]    flush_cnt;

  logic           ready_in_s;
  logic [D*W-1:0] ctrl_out_s;
  logic [D-1:0]   valid_out_s;
  logic [1:0]     bubble_cnt_s;
  logic [1:0]     flush_cnt_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .ready_in(ready_in), .bubble_vec(bubble_vec), .flush_vec(flush_vec),
    .cnt_clear(cnt_clear), .ctrl_out(ctrl_out), .valid_out(valid_out),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  ctrl_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .ready_in(ready_in_s), .bubble_vec(bubble_vec), .flush_vec(flush_vec),
    .cnt_clear(cnt_clear), .ctrl_out(ctrl_out_s), .valid_out(valid_out_s),
    .bubble_cnt(bubble_cnt_s), .flush_cnt(flush_cnt_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ctrl_in = '0; valid_in = 1'b0;
    bubble_vec = '0; flush_vec = '0; cnt_clear = 1'b0;
    step(); step();
    checks++; if (ctrl_out !== 30'h0) begin errors++; $display("FAIL reset_ctrl: got %h want %h", ctrl_out, 30'h0); end
    checks++; if (valid_out !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b want 000", valid_out); end
    checks++; if (bubble_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bubble_cnt, flush_cnt); end
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_in); end
    checks++; if (ctrl_out_s !== 30'h0 || valid_out_s !== 3'b000 || ready_in_s !== 1'b1 || flush_cnt_s !== 2'd0 || bubble_cnt_s !== 2'd0) begin
      errors++; $display("FAIL reset_twin: got %h %b %b %0d %0d want 0 000 1 0 0", ctrl_out_s, valid_out_s, ready_in_s, flush_cnt_s, bubble_cnt_s);
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_stream();
    valid_in = 1'b1; ctrl_in = 10'h001; step();
    checks++; if (ctrl_out !== {10'h000, 10'h000, 10'h001} || valid_out !== 3'b001) begin
      errors++; $display("FAIL stream_c1: got %h %b want %h 001", ctrl_out, valid_out, {10'h000, 10'h000, 10'h001});
    end
    ctrl_in = 10'h002; step();
    ctrl_in = 10'h003; step();
    checks++; if (ctrl_out !== {10'h001, 10'h002, 10'h003}) begin
      errors++; $display("FAIL stream_c3_ctrl: got %h want %h", ctrl_out, {10'h001, 10'h002, 10'h003});
    end
    checks++; if (valid_out !== 3'b111) begin errors++; $display("FAIL stream_c3_valid: got %b want 111", valid_out); end
  endtask

  task automatic test_mid_stall();
    ctrl_in = 10'h0A5; step();
    ctrl_in = 10'h0B6; step();
    ctrl_in = 10'h0C7; bubble_vec = 3'b010; #1;
    checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", ready_in); end
    step();
    checks++; if (ctrl_out !== {10'h000, 10'h0A5, 10'h0B6} || valid_out !== 3'b011) begin
      errors++; $display("FAIL stall_state: got %h %b want %h 011", ctrl_out, valid_out, {10'h000, 10'h0A5, 10'h0B6});
    end
    checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL stall_bcnt: got %0d want 1", bubble_cnt); end
    bubble_vec = 3'b000; step();
    checks++; if (ctrl_out !== {10'h0A5, 10'h0B6, 10'h0C7} || valid_out !== 3'b111 || bubble_cnt !== 16'd1) begin
      errors++; $display("FAIL stall_release: got %h %b %0d want %h 111 1", ctrl_out, valid_out, bubble_cnt, {10'h0A5, 10'h0B6, 10'h0C7});
    end
  endtask

  task automatic test_hold_over_flush();
    ctrl_in = 10'h0D8; bubble_vec = 3'b001; flush_vec = 3'b001; step();
    checks++; if (ctrl_out !== {10'h0B6, 10'h000, 10'h0C7} || valid_out !== 3'b101) begin
      errors++; $display("FAIL hof_state: got %h %b want %h 101", ctrl_out, valid_out, {10'h0B6, 10'h000, 10'h0C7});
    end
    checks++; if (flush_cnt !== 16'd0 || bubble_cnt !== 16'd2) begin
      errors++; $display("FAIL hof_cnt: got f=%0d b=%0d want f=0 b=2", flush_cnt, bubble_cnt);
    end
    bubble_vec = 3'b000; flush_vec = 3'b000;
  endtask

  task automatic test_flush();
    step();
    ctrl_in = 10'h0E9; step();
    checks++; if (ctrl_out !== {10'h0C7, 10'h0D8, 10'h0E9} || valid_out !== 3'b111) begin
      errors++; $display("FAIL flush_pre: got %h %b want %h 111", ctrl_out, valid_out, {10'h0C7, 10'h0D8, 10'h0E9});
    end
    ctrl_in = 10'h0FA; flush_vec = 3'b011; step();
    checks++; if (ctrl_out !== {10'h0D8, 10'h000, 10'h000} || valid_out !== 3'b100) begin
      errors++; $display("FAIL flush_state: got %h %b want %h 100", ctrl_out, valid_out, {10'h0D8, 10'h000, 10'h000});
    end
    checks++; if (flush_cnt !== 16'd1 || bubble_cnt !== 16'd2) begin
      errors++; $display("FAIL flush_cnt: got f=%0d b=%0d want f=1 b=2", flush_cnt, bubble_cnt);
    end
    flush_vec = 3'b000;
  endtask

  task automatic test_sat_clear();
    cnt_clear = 1'b1; step();
    checks++; if (bubble_cnt !== 16'd0 || flush_cnt !== 16'd0 || bubble_cnt_s !== 2'd0) begin
      errors++; $display("FAIL clr_idle: got %0d/%0d/%0d want 0/0/0", bubble_cnt, flush_cnt, bubble_cnt_s);
    end
    cnt_clear = 1'b0; bubble_vec = 3'b001;
    for (int k = 0; k < 4; k++) step();
    checks++; if (bubble_cnt_s !== 2'd3) begin errors++; $display("FAIL sat_bcnt: got %0d want 3", bubble_cnt_s); end
    checks++; if (bubble_cnt !== 16'd4) begin errors++; $display("FAIL wide_bcnt: got %0d want 4", bubble_cnt); end
    cnt_clear = 1'b1; step();
    checks++; if (bubble_cnt_s !== 2'd0 || bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL clr_over_inc: got %0d/%0d want 0/0", bubble_cnt_s, bubble_cnt);
    end
    cnt_clear = 1'b0; bubble_vec = 3'b000;
  endtask

  task automatic test_async_reset();
    ctrl_in = 10'h111; step();
    ctrl_in = 10'h122; step();
    ctrl_in = 10'h133; step();
    bubble_vec = 3'b010; step();
    bubble_vec = 3'b100; step();
    checks++; if (ctrl_out !== {10'h000, 10'h122, 10'h133} || bubble_cnt !== 16'd1 || ready_in !== 1'b0) begin
      errors++; $display("FAIL pre_rst: got %h b=%0d r=%b want %h b=1 r=0", ctrl_out, bubble_cnt, ready_in, {10'h000, 10'h122, 10'h133});
    end
    #2 rst = 1'b1; #1;
    checks++; if (ctrl_out !== 30'h0 || valid_out !== 3'b000 || bubble_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL async_rst: got %h %b %0d %0d want 0 000 0 0", ctrl_out, valid_out, bubble_cnt, flush_cnt);
    end
    #1 rst = 1'b0;
    step();
    checks++; if (ctrl_out !== 30'h0 || valid_out !== 3'b000 || bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL post_rst_hold: got %h %b %0d want 0 000 0", ctrl_out, valid_out, bubble_cnt);
    end
    bubble_vec = 3'b000; ctrl_in = 10'h155; step();
    checks++; if (ctrl_out !== {10'h000, 10'h000, 10'h155} || valid_out !== 3'b001) begin
      errors++; $display("FAIL post_rst_load: got %h %b want %h 001", ctrl_out, valid_out, {10'h000, 10'h000, 10'h155});
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mid_stall();
    test_hold_over_flush();
    test_flush();
    test_sat_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ctrl_pipe
